// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: per-channel synchroniser,
// saturating stability counter, debounced level and edge pulses.
module debounce_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned LENGTH      = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_sig,
  output logic [CHANNELS-1:0] o_sig,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_change
);

  localparam logic [LENGTH-1:0] CNT_MAX = '1;
  localparam logic [LENGTH-1:0] CNT_ONE = LENGTH'(1);
  localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_VAL}};

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] prev_d;
  logic [LENGTH-1:0]   cnt_q  [CHANNELS];
  logic [LENGTH-1:0]   cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] sig_q;
  logic [CHANNELS-1:0] sig_d;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] fall_d;
  logic                change_q;
  logic                change_d;

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] sat;
  logic [CHANNELS-1:0] upd;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain shift and previous-sample capture
  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_d[i] = '0;
    end
    sync_d[0] = i_sig;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = s;
  end

  // Stability counter: clear on change, count up, saturate
  always_comb begin
    sat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      sat[c] = (cnt_q[c] == CNT_MAX);
      if (prev_q[c] != s[c]) begin
        cnt_d[c] = '0;
      end else if (!sat[c]) begin
        cnt_d[c] = cnt_q[c] + CNT_ONE;
      end
    end
  end

  // Accept a stable new level and raise the matching edge pulse
  always_comb begin
    sig_d  = sig_q;
    rise_d = '0;
    fall_d = '0;
    upd    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      upd[c] = sat[c] && (prev_q[c] != sig_q[c]);
      if (upd[c]) begin
        sig_d[c]  = prev_q[c];
        rise_d[c] = prev_q[c];
        fall_d[c] = ~prev_q[c];
      end
    end
    change_d = |(rise_d | fall_d);
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RST_VEC;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
      prev_q   <= RST_VEC;
      sig_q    <= RST_VEC;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      prev_q   <= prev_d;
      sig_q    <= sig_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign o_sig    = sig_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
  assign o_change = change_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random
// bouncing inputs, scoreboarded against a stability-window model.
module tb_debounce_multi;

  localparam int   CH   = 4;
  localparam int   LEN  = 3;
  localparam int   SYNC = 2;
  localparam logic RV   = 1'b0;
  localparam int   WIN  = 1 << LEN;

  typedef struct packed {
    logic [CH-1:0] sig;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          chg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig;
  logic [CH-1:0] o_sig;
  logic [CH-1:0] o_rise;
  logic [CH-1:0] o_fall;
  logic          o_change;

  exp_t          sb_q[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_sig;
  exp_t          e_mon;

  int errors = 0;
  int checks = 0;
  int rise_cnt[CH];
  int fall_cnt[CH];
  int chg_cnt;
  int both_cnt;

  logic [CH-1:0] rx;
  int            hold[CH];

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS   (CH),
    .LENGTH     (LEN),
    .SYNC_STAGES(SYNC),
    .RESET_VAL  (RV)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_sig   (sig),
    .o_sig   (o_sig),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_change(o_change)
  );

  task automatic chk(input string nm, input logic [CH-1:0] act,
                     input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a channel takes level v when the WIN samples seen
  // SYNC+1..SYNC+WIN edges ago are all v; reset makes history RV.
  task automatic model_edge(input logic [CH-1:0] x, input logic r);
    exp_t          e;
    logic [CH-1:0] tmp;
    int            ones;
    e = '0;
    if (r) begin
      hist.delete();
      for (int i = 0; i < SYNC + WIN; i++) hist.push_back({CH{RV}});
      m_sig = {CH{RV}};
    end else begin
      hist.push_back(x);
      while (hist.size() > SYNC + WIN + 1) void'(hist.pop_front());
      if (hist.size() == SYNC + WIN + 1) begin
        for (int c = 0; c < CH; c++) begin
          ones = 0;
          for (int i = 0; i < WIN; i++) begin
            tmp = hist[i];
            ones += int'(tmp[c]);
          end
          if (ones == WIN && !m_sig[c]) begin
            m_sig[c] = 1'b1;
            e.rise[c] = 1'b1;
          end else if (ones == 0 && m_sig[c]) begin
            m_sig[c] = 1'b0;
            e.fall[c] = 1'b1;
          end
        end
      end
    end
    e.sig = m_sig;
    e.chg = |(e.rise | e.fall);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [CH-1:0] x, input logic r);
    @(negedge clk);
    sig = x;
    rst = r;
    @(posedge clk);
    model_edge(x, r);
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
    chg_cnt  = 0;
    both_cnt = 0;
  endtask

  // Monitor: one expected response per clock, compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e_mon = sb_q.pop_front();
      chk("o_sig", o_sig, e_mon.sig);
      chk("o_rise", o_rise, e_mon.rise);
      chk("o_fall", o_fall, e_mon.fall);
      chk("o_change", {{(CH-1){1'b0}}, o_change},
          {{(CH-1){1'b0}}, e_mon.chg});
      for (int c = 0; c < CH; c++) begin
        rise_cnt[c] += int'(o_rise[c]);
        fall_cnt[c] += int'(o_fall[c]);
      end
      if (o_change === 1'b1) chg_cnt++;
      if (o_fall[0] === 1'b1 && o_rise[3] === 1'b1) both_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sig = '0;
    rst = 1'b1;
    clr_cnt();

    // reset with all inputs high, then all rise together
    repeat (3) step(4'b1111, 1'b1);
    clr_cnt();
    repeat (14) step(4'b1111, 1'b0);
    for (int c = 0; c < CH; c++) chk_int("reset_release_rise", rise_cnt[c], 1);
    chk_int("reset_release_change", chg_cnt, 1);

    // clean step on channel 0
    step(4'b0000, 1'b1);
    repeat (12) step(4'b0000, 1'b0);
    clr_cnt();
    repeat (110) step(4'b0001, 1'b0);
    chk_int("clean_step_rise", rise_cnt[0], 1);
    chk_int("clean_step_fall", fall_cnt[0], 0);

    // glitch of 7 cycles rejected, 8 cycles accepted
    clr_cnt();
    repeat (7) step(4'b0011, 1'b0);
    repeat (15) step(4'b0001, 1'b0);
    chk_int("glitch7_rise", rise_cnt[1], 0);
    chk_int("glitch7_fall", fall_cnt[1], 0);
    clr_cnt();
    repeat (8) step(4'b0011, 1'b0);
    repeat (15) step(4'b0001, 1'b0);
    chk_int("pulse8_rise", rise_cnt[1], 1);
    chk_int("pulse8_fall", fall_cnt[1], 1);

    // bounce train on channel 2, then held high
    clr_cnt();
    for (int seg = 0; seg < 10; seg++) begin
      repeat (3) step((seg % 2 == 0) ? 4'b0101 : 4'b0001, 1'b0);
    end
    repeat (20) step(4'b0101, 1'b0);
    chk_int("bounce_rise", rise_cnt[2], 1);
    chk_int("bounce_fall", fall_cnt[2], 0);

    // opposite directions on channels 0 and 3 in the same cycle
    clr_cnt();
    repeat (20) step(4'b1100, 1'b0);
    chk_int("simul_both", both_cnt, 1);
    chk_int("simul_change", chg_cnt, 1);
    chk_int("simul_rise3", rise_cnt[3], 1);
    chk_int("simul_fall0", fall_cnt[0], 1);

    // reset in the middle of a count
    step(4'b0000, 1'b1);
    repeat (12) step(4'b0000, 1'b0);
    clr_cnt();
    repeat (5) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    repeat (9) step(4'b0100, 1'b0);
    chk_int("midreset_no_pulse", rise_cnt[2], 0);
    repeat (10) step(4'b0100, 1'b0);
    chk_int("midreset_late_rise", rise_cnt[2], 1);

    // random bouncing inputs with occasional reset
    rx = '0;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    repeat (3000) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          rx[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 12));
        end
        hold[c]--;
      end
      step(rx, ($urandom_range(0, 199) == 0));
    end
    repeat (15) step(rx, 1'b0);

    repeat (2) @(negedge clk);
    chk_int("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
